// File: rtl/text_printer_pkg.sv
// Shared constants for the text printer: custom-instruction opcodes,
// FSM encoding, the job kind held during a transaction, and control characters.
package text_printer_pkg;

  localparam logic [3:0] OP_COLOR = 4'h0;
  localparam logic [3:0] OP_CHAR  = 4'h2;
  localparam logic [3:0] OP_CLEAR = 4'h3;
  localparam logic [3:0] OP_INFO  = 4'hF;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    INFO,
    INFO_WAIT,
    IDLE,
    ISSUE,
    WAIT
  } stateType;

  typedef enum logic [1:0] {
    KIND_CLEAR,
    KIND_COLOR,
    KIND_CHAR
  } kindType;

endpackage

// File: rtl/text_printer_fifo.sv
// Character FIFO with registered read/write pointers (one extra wrap bit)
// and a flush that discards everything currently stored.
module text_printer_fifo #(
  parameter int depthLog2 = 4,
  parameter int width     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [width-1:0] pushData,
  input  logic             pop,
  output logic [width-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int depth = 1 << depthLog2;

  logic [width-1:0]   mem [depth];
  logic [depthLog2:0] wrPtrReg;
  logic [depthLog2:0] rdPtrReg;
  logic               doPush;

  assign doPush = push && !full;

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtrReg[depthLog2-1:0]] <= pushData;
  end

  // A flush moves the read pointer to the pre-push write pointer, so a
  // character pushed in the same cycle survives the flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
      if (flush) rdPtrReg <= wrPtrReg;
      else if (pop && !empty) rdPtrReg <= rdPtrReg + 1'b1;
    end
  end

  assign empty   = (wrPtrReg == rdPtrReg);
  assign full    = (wrPtrReg[depthLog2] != rdPtrReg[depthLog2]) &&
                   (wrPtrReg[depthLog2-1:0] == rdPtrReg[depthLog2-1:0]);
  assign popData = mem[rdPtrReg[depthLog2-1:0]];

endmodule

// File: rtl/text_printer.sv
// Custom-instruction initiator towards the text controller: reads screen
// geometry after reset, then serves clear, colour and character requests.
module text_printer
  import text_printer_pkg::*;
#(
  parameter logic [7:0] customInstructionNr = 8'd0,
  parameter int         fifoDepthLog2       = 4,
  parameter int         timeoutCycles       = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        charValid,
  input  logic [7:0]  charData,
  output logic        charReady,
  input  logic        clearReq,
  input  logic        colorReq,
  input  logic [15:0] colorData,
  output logic [7:0]  ciN,
  output logic [31:0] ciDataA,
  output logic [31:0] ciDataB,
  output logic        ciStart,
  output logic        ciCke,
  input  logic        ciDone,
  input  logic [31:0] ciResult,
  output logic [6:0]  nrOfLines,
  output logic [6:0]  nrOfCharsPerLine,
  output logic        infoValid,
  output logic        busy,
  output logic        timeoutError
);

  localparam int            cntW  = $clog2(timeoutCycles + 1);
  localparam logic [cntW-1:0] TLAST = cntW'(timeoutCycles - 1);

  stateType        stateReg, stateNext;
  kindType         kindReg, kindNext;
  logic [3:0]      opReg, opNext;
  logic [31:0]     argReg, argNext;
  logic [cntW-1:0] cntReg;
  logic            aliveReg;
  logic            clearPendReg, colorPendReg;
  logic [15:0]     colorReg;
  logic            infoValidReg, timeoutReg;
  logic [6:0]      linesReg, charsReg;

  logic            fifoPop, fifoFlush, fifoFull, fifoEmpty;
  logic [7:0]      fifoHead;
  logic            finish, timeoutHit, infoLatch;
  logic            unusedBits;

  assign unusedBits = &{1'b0, ciResult[31:23], ciResult[15:7]};

  text_printer_fifo #(
    .depthLog2(fifoDepthLog2),
    .width    (8)
  ) fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (fifoFlush),
    .push    (charValid && charReady),
    .pushData(charData),
    .pop     (fifoPop),
    .popData (fifoHead),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  always_comb begin
    stateNext  = stateReg;
    kindNext   = kindReg;
    opNext     = opReg;
    argNext    = argReg;
    fifoPop    = 1'b0;
    fifoFlush  = 1'b0;
    finish     = 1'b0;
    timeoutHit = 1'b0;
    infoLatch  = 1'b0;
    case (stateReg)
      // The first cycle after reset only loads the opcode; the start follows.
      INFO: begin
        opNext  = OP_INFO;
        argNext = '0;
        if (aliveReg) begin
          if (ciDone) begin
            infoLatch = 1'b1;
            stateNext = IDLE;
          end else begin
            stateNext = INFO_WAIT;
          end
        end
      end
      INFO_WAIT: begin
        if (ciDone) begin
          infoLatch = 1'b1;
          stateNext = IDLE;
        end else if (cntReg == TLAST) begin
          timeoutHit = 1'b1;
          stateNext  = IDLE;
        end
      end
      IDLE: begin
        if (clearPendReg) begin
          kindNext  = KIND_CLEAR;
          opNext    = OP_CLEAR;
          argNext   = '0;
          stateNext = ISSUE;
        end else if (colorPendReg) begin
          kindNext  = KIND_COLOR;
          opNext    = OP_COLOR;
          argNext   = {16'd0, colorReg};
          stateNext = ISSUE;
        end else if (!fifoEmpty) begin
          if (fifoHead == CHAR_CR) begin
            fifoPop = 1'b1;
          end else begin
            kindNext  = KIND_CHAR;
            opNext    = OP_CHAR;
            argNext   = {24'd0, fifoHead};
            stateNext = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (ciDone) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (ciDone) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end else if (cntReg == TLAST) begin
          timeoutHit = 1'b1;
          finish     = 1'b1;
          stateNext  = IDLE;
        end
      end
      default: stateNext = INFO;
    endcase
    // An abandoned job is retired exactly like a completed one.
    if (finish) begin
      case (kindReg)
        KIND_CLEAR: fifoFlush = 1'b1;
        KIND_CHAR:  fifoPop   = 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg     <= INFO;
      kindReg      <= KIND_CHAR;
      opReg        <= '0;
      argReg       <= '0;
      cntReg       <= '0;
      aliveReg     <= 1'b0;
      clearPendReg <= 1'b0;
      colorPendReg <= 1'b0;
      colorReg     <= '0;
      infoValidReg <= 1'b0;
      linesReg     <= '0;
      charsReg     <= '0;
      timeoutReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      kindReg  <= kindNext;
      opReg    <= opNext;
      argReg   <= argNext;
      aliveReg <= 1'b1;
      if (stateReg == ISSUE || stateReg == INFO) cntReg <= cntW'(1);
      else cntReg <= cntReg + 1'b1;
      clearPendReg <= clearReq | (clearPendReg & ~(finish && kindReg == KIND_CLEAR));
      colorPendReg <= colorReq | (colorPendReg & ~(finish && kindReg == KIND_COLOR));
      if (colorReq) colorReg <= colorData;
      if (infoLatch) begin
        infoValidReg <= 1'b1;
        linesReg     <= ciResult[22:16];
        charsReg     <= ciResult[6:0];
      end
      if (timeoutHit) timeoutReg <= 1'b1;
    end
  end

  assign ciN              = customInstructionNr;
  assign ciCke            = aliveReg;
  assign ciStart          = (aliveReg && stateReg == INFO) || (stateReg == ISSUE);
  assign ciDataA          = {28'd0, opReg};
  assign ciDataB          = argReg;
  assign charReady        = aliveReg && !fifoFull;
  assign nrOfLines        = linesReg;
  assign nrOfCharsPerLine = charsReg;
  assign infoValid        = infoValidReg;
  assign timeoutError     = timeoutReg;
  assign busy             = !(stateReg == IDLE && fifoEmpty && !clearPendReg && !colorPendReg);

endmodule

// File: tb/tb_text_printer.sv
// Directed bench for text_printer: a configurable ciDone responder plus a
// transaction monitor, driven by one linear sequence of steps.
module tb_text_printer;

  logic        clock = 1'b0;
  logic        reset;
  logic        charValid;
  logic [7:0]  charData;
  logic        charReady;
  logic        clearReq;
  logic        colorReq;
  logic [15:0] colorData;
  logic [7:0]  ciN;
  logic [31:0] ciDataA;
  logic [31:0] ciDataB;
  logic        ciStart;
  logic        ciCke;
  logic        ciDone;
  logic [31:0] ciResult;
  logic [6:0]  nrOfLines;
  logic [6:0]  nrOfCharsPerLine;
  logic        infoValid;
  logic        busy;
  logic        timeoutError;

  int compared   = 0;
  int mismatched = 0;

  text_printer dut (
    .clock           (clock),
    .reset           (reset),
    .charValid       (charValid),
    .charData        (charData),
    .charReady       (charReady),
    .clearReq        (clearReq),
    .colorReq        (colorReq),
    .colorData       (colorData),
    .ciN             (ciN),
    .ciDataA         (ciDataA),
    .ciDataB         (ciDataB),
    .ciStart         (ciStart),
    .ciCke           (ciCke),
    .ciDone          (ciDone),
    .ciResult        (ciResult),
    .nrOfLines       (nrOfLines),
    .nrOfCharsPerLine(nrOfCharsPerLine),
    .infoValid       (infoValid),
    .busy            (busy),
    .timeoutError    (timeoutError)
  );

  always #5 clock = ~clock;

  // Responder: lat=0 answers in the start cycle, otherwise lat cycles later.
  logic stall;
  int   lat;
  logic respBusy;
  int   respCnt;

  assign ciResult = 32'h002C_0050;
  assign ciDone   = !stall && ((lat == 0) ? ciStart : (respBusy && respCnt >= lat));

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      respBusy <= 1'b0;
      respCnt  <= 0;
    end else if (ciDone) begin
      respBusy <= 1'b0;
    end else if (ciStart) begin
      respBusy <= 1'b1;
      respCnt  <= 1;
    end else if (respBusy) begin
      respCnt <= respCnt + 1;
    end
  end

  // Monitor: logs each start, counts held cycles, flags instability.
  logic [3:0]  logA [$];
  logic [31:0] logB [$];
  int          holdQ [$];
  logic [31:0] holdA, holdB;
  int          holdCnt;
  logic        inTx;
  logic        prevStart;
  int          doubleStart = 0;
  int          unstable    = 0;
  int          upperA      = 0;

  always @(negedge clock) begin
    if (reset) begin
      inTx      <= 1'b0;
      prevStart <= 1'b0;
    end else begin
      if (ciStart) begin
        if (prevStart) doubleStart <= doubleStart + 1;
        if (ciDataA[31:4] != 28'd0) upperA <= upperA + 1;
        logA.push_back(ciDataA[3:0]);
        logB.push_back(ciDataB);
        holdA   <= ciDataA;
        holdB   <= ciDataB;
        holdCnt <= 1;
        inTx    <= 1'b1;
        if (ciDone) begin
          holdQ.push_back(1);
          inTx <= 1'b0;
        end
      end else if (inTx) begin
        holdCnt <= holdCnt + 1;
        if (ciDataA !== holdA || ciDataB !== holdB) unstable <= unstable + 1;
        if (ciDone) begin
          holdQ.push_back(holdCnt + 1);
          inTx <= 1'b0;
        end
      end
      prevStart <= ciStart;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic pushChar(input logic [7:0] c);
    for (int i = 0; i < 20 && !charReady; i++) tick();
    charValid = 1'b1;
    charData  = c;
    tick();
    charValid = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic clearLogs;
    logA.delete();
    logB.delete();
    holdQ.delete();
  endtask

  initial begin
    reset     = 1'b1;
    charValid = 1'b0;
    charData  = 8'h00;
    clearReq  = 1'b0;
    colorReq  = 1'b0;
    colorData = 16'h0000;
    stall     = 1'b0;
    lat       = 0;

    // Reset state
    tick(); tick(); tick();
    check("rst_ciStart", {31'd0, ciStart}, 32'd0);
    check("rst_ciDataA", ciDataA, 32'd0);
    check("rst_ciDataB", ciDataB, 32'd0);
    check("rst_infoValid", {31'd0, infoValid}, 32'd0);
    check("rst_lines", {25'd0, nrOfLines}, 32'd0);
    check("rst_charReady", {31'd0, charReady}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_timeout", {31'd0, timeoutError}, 32'd0);

    // Screen info read with immediate completion
    clearLogs();
    reset = 1'b0;
    for (int i = 0; i < 50 && !infoValid; i++) tick();
    tick();
    check("info_valid", {31'd0, infoValid}, 32'd1);
    check("info_count", logA.size(), 32'd1);
    check("info_op", {28'd0, logA[0]}, 32'hF);
    check("info_lines", {25'd0, nrOfLines}, 32'd44);
    check("info_chars", {25'd0, nrOfCharsPerLine}, 32'd80);
    check("info_cke", {31'd0, ciCke}, 32'd1);
    check("info_ciN", {24'd0, ciN}, 32'd0);
    waitIdle("info_idle", 20);

    // "A", CR, LF with 3-cycle latency
    clearLogs();
    lat = 3;
    pushChar(8'h41);
    pushChar(8'h0D);
    pushChar(8'h0A);
    waitIdle("crlf_idle", 100);
    check("crlf_count", logA.size(), 32'd2);
    check("crlf_op0", {28'd0, logA[0]}, 32'h2);
    check("crlf_b0", logB[0], 32'h41);
    check("crlf_op1", {28'd0, logA[1]}, 32'h2);
    check("crlf_b1", logB[1], 32'h0A);
    check("crlf_hold0", holdQ[0], 32'd4);
    check("crlf_hold1", holdQ[1], 32'd4);

    // Fill the FIFO while the responder stalls
    clearLogs();
    lat   = 1;
    stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill_ready%0d", i), {31'd0, charReady}, 32'd1);
      charValid = 1'b1;
      charData  = 8'h61 + 8'(i);
      tick();
    end
    charValid = 1'b0;
    check("full_ready", {31'd0, charReady}, 32'd0);
    charValid = 1'b1;
    charData  = 8'h7A;
    tick(); tick();
    charValid = 1'b0;
    check("full_refused", {31'd0, charReady}, 32'd0);
    stall = 1'b0;
    waitIdle("full_idle", 300);
    check("full_count", logA.size(), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("full_order%0d", i), logB[i], 32'h61 + i);

    // Clear and colour together with chars queued (first char already in flight)
    clearLogs();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) pushChar(8'h70 + 8'(i));
    clearReq  = 1'b1;
    colorReq  = 1'b1;
    colorData = 16'hF800;
    tick();
    clearReq  = 1'b0;
    colorReq  = 1'b0;
    colorData = 16'h0000;
    stall     = 1'b0;
    waitIdle("clr_idle", 200);
    check("clr_count", logA.size(), 32'd3);
    check("clr_first_b", logB[0], 32'h70);
    check("clr_op", {28'd0, logA[1]}, 32'h3);
    check("clr_b", logB[1], 32'h0);
    check("col_op", {28'd0, logA[2]}, 32'h0);
    check("col_b", logB[2], 32'h0000F800);

    // Timeout on a character that never completes
    clearLogs();
    stall = 1'b1;
    pushChar(8'h58);
    pushChar(8'h59);
    for (int i = 0; i < 990; i++) tick();
    check("to_early", {31'd0, timeoutError}, 32'd0);
    for (int i = 0; i < 100 && !timeoutError; i++) tick();
    check("to_set", {31'd0, timeoutError}, 32'd1);
    stall = 1'b0;
    waitIdle("to_idle", 100);
    check("to_count", logA.size(), 32'd2);
    check("to_b0", logB[0], 32'h58);
    check("to_b1", logB[1], 32'h59);
    check("to_sticky", {31'd0, timeoutError}, 32'd1);

    // Reset in the middle of a transaction
    stall = 1'b1;
    pushChar(8'h51);
    for (int i = 0; i < 10 && !ciStart; i++) tick();
    check("mid_started", {31'd0, ciStart}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_ciStart", {31'd0, ciStart}, 32'd0);
    check("mid_ciDataA", ciDataA, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    tick(); tick();
    clearLogs();
    stall = 1'b0;
    lat   = 0;
    reset = 1'b0;
    for (int i = 0; i < 50 && !infoValid; i++) tick();
    tick();
    check("mid_first_op", {28'd0, logA[0]}, 32'hF);
    check("mid_count", logA.size(), 32'd1);
    check("mid_timeout", {31'd0, timeoutError}, 32'd0);
    waitIdle("mid_idle", 20);

    // Protocol properties collected over the whole run
    check("proto_double_start", doubleStart, 32'd0);
    check("proto_unstable", unstable, 32'd0);
    check("proto_upperA", upperA, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
